// File: rtl/aes_pkg.sv
// Shared AES definitions: block width, FSM encoding and the byte-level
// transforms used by the round datapath and the key schedule.
package aes_pkg;

    localparam int unsigned AES_BLOCK_W = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } aes_state_e;

    function automatic int unsigned nr_of(input int unsigned nk);
        return nk + 6;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = '0;
        x = a;
        y = b;
        for (int unsigned i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254, inv(0)=0) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] e;
        inv = 8'h01;
        e   = 8'hfe;
        for (int unsigned i = 0; i < 8; i++) begin
            inv = gmul(inv, inv);
            if (e[7]) inv = gmul(inv, x);
            e = e << 1;
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input int unsigned j);
        logic [7:0] r;
        r = 8'h01;
        for (int unsigned k = 1; k < 10; k++) begin
            if (k < j) r = xtime(r);
        end
        return r;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [AES_BLOCK_W-1:0] sub_bytes(input logic [AES_BLOCK_W-1:0] s);
        logic [AES_BLOCK_W-1:0] o;
        logic [AES_BLOCK_W-1:0] x;
        o = '0;
        x = s;
        for (int unsigned i = 0; i < 16; i++) begin
            o = {o[119:0], sbox(x[127:120])};
            x = x << 8;
        end
        return o;
    endfunction

    // Byte k = 4*col + row sits at [127-8k -: 8]; row r rotates left by r columns
    function automatic logic [AES_BLOCK_W-1:0] shift_rows(input logic [AES_BLOCK_W-1:0] s);
        return {s[127:120], s[87:80],   s[47:40],   s[7:0],
                s[95:88],   s[55:48],   s[15:8],    s[103:96],
                s[63:56],   s[23:16],   s[111:104], s[71:64],
                s[31:24],   s[119:112], s[79:72],   s[39:32]};
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        a0 = a[31:24];
        a1 = a[23:16];
        a2 = a[15:8];
        a3 = a[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [AES_BLOCK_W-1:0] mix_columns(input logic [AES_BLOCK_W-1:0] s);
        logic [AES_BLOCK_W-1:0] o;
        logic [AES_BLOCK_W-1:0] x;
        o = '0;
        x = s;
        for (int unsigned c = 0; c < 4; c++) begin
            o = {o[95:0], mix_column(x[127:96])};
            x = x << 32;
        end
        return o;
    endfunction

endpackage

// File: rtl/cipher_round.sv
// One combinational AES round: SubBytes, ShiftRows, MixColumns (skipped in
// the final round) and AddRoundKey.
module cipher_round
    import aes_pkg::*;
(
    input  logic [AES_BLOCK_W-1:0] i_state,
    input  logic [AES_BLOCK_W-1:0] i_round_key,
    input  logic                   i_final,
    output logic [AES_BLOCK_W-1:0] o_state
);

    logic [AES_BLOCK_W-1:0] shifted;

    assign shifted = shift_rows(sub_bytes(i_state));
    assign o_state = (i_final ? shifted : mix_columns(shifted)) ^ i_round_key;

endmodule

// File: rtl/cipher_iterative.sv
// Iterative AES encryption core: one round per clock, one block in flight,
// valid/ready handshake on input and output, key latched per block.
module cipher_iterative
    import aes_pkg::*;
#(
    parameter int unsigned NK = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [AES_BLOCK_W-1:0] i_data,
    input  logic [32*NK-1:0]       i_key,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [AES_BLOCK_W-1:0] o_data,
    output logic                   o_busy
);

    localparam int unsigned NR = nr_of(NK);
    localparam int unsigned CW = $clog2(NR + 1);
    localparam int unsigned KW = 32 * NK;
    localparam int unsigned NW = 4 * (NR + 1);
    localparam int unsigned SW = 32 * NW;

    aes_state_e             fsm_q,  fsm_d;
    logic [AES_BLOCK_W-1:0] st_q,   st_d;
    logic [AES_BLOCK_W-1:0] data_q, data_d;
    logic [KW-1:0]          key_q,  key_d;
    logic [CW-1:0]          rnd_q,  rnd_d;
    logic [SW-1:0]          sched;
    logic [AES_BLOCK_W-1:0] rk;
    logic [AES_BLOCK_W-1:0] round_out;
    logic                   last_rnd;

    // Schedule is built as a shift register of words: w[i-1] is always the
    // bottom word and w[i-NK] sits NK-1 words above it; w[0] ends at the MSBs.
    always_comb begin : key_expansion
        logic [SW-1:0] acc;
        logic [31:0]   t;
        acc = SW'(key_q);
        t   = '0;
        for (int unsigned i = NK; i < NW; i++) begin
            t = acc[31:0];
            if (i % NK == 0) begin
                t = sub_word(rot_word(t)) ^ {rcon(i / NK), 24'h000000};
            end else if (NK > 6 && i % NK == 4) begin
                t = sub_word(t);
            end
            acc = {acc[SW-33:0], 32'(acc >> (32 * (NK - 1))) ^ t};
        end
        sched = acc;
    end

    assign rk       = AES_BLOCK_W'(sched >> (128 * (NR - 32'(rnd_q))));
    assign last_rnd = (rnd_q == CW'(NR));

    cipher_round u_round (
        .i_state     (st_q),
        .i_round_key (rk),
        .i_final     (last_rnd),
        .o_state     (round_out)
    );

    always_comb begin
        fsm_d   = fsm_q;
        st_d    = st_q;
        data_d  = data_q;
        key_d   = key_q;
        rnd_d   = rnd_q;
        o_ready = 1'b0;
        unique case (fsm_q)
            IDLE: o_ready = 1'b1;
            RUN: begin
                st_d  = round_out;
                rnd_d = rnd_q + CW'(1);
                if (last_rnd) begin
                    data_d = round_out;
                    rnd_d  = '0;
                    fsm_d  = DONE;
                end
            end
            DONE: begin
                o_ready = i_ready;
                if (i_ready) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
        // Round key 0 is the leading four key words, so it comes straight from i_key
        if (i_valid && o_ready) begin
            key_d = i_key;
            st_d  = i_data ^ i_key[KW-1 -: AES_BLOCK_W];
            rnd_d = CW'(1);
            fsm_d = RUN;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fsm_q  <= IDLE;
            st_q   <= '0;
            data_q <= '0;
            key_q  <= '0;
            rnd_q  <= '0;
        end else begin
            fsm_q  <= fsm_d;
            st_q   <= st_d;
            data_q <= data_d;
            key_q  <= key_d;
            rnd_q  <= rnd_d;
        end
    end

    assign o_valid = (fsm_q == DONE);
    assign o_busy  = (fsm_q == RUN);
    assign o_data  = data_q;

endmodule

// File: tb/tb_cipher_iterative.sv
// Directed-vector bench for cipher_iterative using FIPS-197 known answers
// for AES-128/192/256, handshake backpressure, back-to-back and reset cases.
module tb_cipher_iterative;

    localparam logic [127:0] PT_A = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K_A  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_A = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_B = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] CT_C = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [191:0] K_192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [255:0] K_256 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT_192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT_256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk;
    logic rst_n;

    logic         v4, rdy4, ov4, ir4, bz4;
    logic [127:0] d4, k4, od4;
    logic         v6, rdy6, ov6, ir6, bz6;
    logic [127:0] d6, od6;
    logic [191:0] k6;
    logic         v8, rdy8, ov8, ir8, bz8;
    logic [127:0] d8, od8;
    logic [255:0] k8;

    int n_chk;
    int n_bad;
    int lat, l6, l8, cyc, outs, last, blk;
    logic will_acc;

    cipher_iterative #(.NK(4)) u4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v4), .o_ready(rdy4), .i_data(d4),
        .i_key(k4), .o_valid(ov4), .i_ready(ir4), .o_data(od4), .o_busy(bz4)
    );
    cipher_iterative #(.NK(6)) u6 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v6), .o_ready(rdy6), .i_data(d6),
        .i_key(k6), .o_valid(ov6), .i_ready(ir6), .o_data(od6), .o_busy(bz6)
    );
    cipher_iterative #(.NK(8)) u8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v8), .o_ready(rdy8), .i_data(d8),
        .i_key(k8), .o_valid(ov8), .i_ready(ir8), .o_data(od8), .o_busy(bz8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send4(input logic [127:0] pt, input logic [127:0] key);
        v4 = 1'b1;
        d4 = pt;
        k4 = key;
        @(negedge clk);
        v4 = 1'b0;
    endtask

    task automatic wait4(output int n);
        n = 0;
        while (!ov4 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    function automatic logic [127:0] bb_pt(input int n);
        case (n)
            0: return PT_A;
            1: return PT_B;
            default: return 128'h0;
        endcase
    endfunction

    function automatic logic [127:0] bb_key(input int n);
        case (n)
            0: return K_A;
            1: return K_B;
            default: return 128'h0;
        endcase
    endfunction

    function automatic logic [127:0] bb_ct(input int n);
        case (n)
            0: return CT_A;
            1: return CT_B;
            default: return CT_C;
        endcase
    endfunction

    initial begin
        n_chk = 0;
        n_bad = 0;
        rst_n = 1'b0;
        v4 = 1'b0; d4 = '0; k4 = '0; ir4 = 1'b1;
        v6 = 1'b0; d6 = '0; k6 = '0; ir6 = 1'b1;
        v8 = 1'b0; d8 = '0; k8 = '0; ir8 = 1'b1;
        repeat (2) @(negedge clk);

        chk("rst_valid", 128'(ov4), 128'd0);
        chk("rst_data",  od4, 128'd0);
        chk("rst_busy",  128'(bz4), 128'd0);
        chk("rst_ready", 128'(rdy4), 128'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // AES-192 and AES-256 in parallel
        v6 = 1'b1; d6 = PT_A; k6 = K_192;
        v8 = 1'b1; d8 = PT_A; k8 = K_256;
        @(negedge clk);
        v6 = 1'b0; v8 = 1'b0;
        lat = 0; l6 = 0; l8 = 0;
        while ((l6 == 0 || l8 == 0) && lat < 40) begin
            @(negedge clk);
            lat++;
            if (ov6 && l6 == 0) begin
                l6 = lat;
                chk("nk6_data", od6, CT_192);
            end
            if (ov8 && l8 == 0) begin
                l8 = lat;
                chk("nk8_data", od8, CT_256);
            end
        end
        chk("nk6_lat", 128'(l6), 128'd12);
        chk("nk8_lat", 128'(l8), 128'd14);
        @(negedge clk);

        // AES-128 basic
        send4(PT_A, K_A);
        wait4(lat);
        chk("a_lat",  128'(lat), 128'd10);
        chk("a_data", od4, CT_A);
        @(negedge clk);
        chk("a_valid_drop", 128'(ov4), 128'd0);
        chk("a_idle_ready", 128'(rdy4), 128'd1);
        chk("a_data_hold",  od4, CT_A);

        // Backpressure in DONE
        ir4 = 1'b0;
        send4(PT_B, K_B);
        wait4(lat);
        chk("b_lat",  128'(lat), 128'd10);
        chk("b_data", od4, CT_B);
        v4 = 1'b1; d4 = 128'h0; k4 = 128'h0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 128'(ov4), 128'd1);
            chk("bp_data",  od4, CT_B);
            chk("bp_ready", 128'(rdy4), 128'd0);
            chk("bp_busy",  128'(bz4), 128'd0);
        end
        ir4 = 1'b1;
        @(negedge clk);
        v4 = 1'b0;
        chk("bp_release_valid", 128'(ov4), 128'd0);
        chk("bp_release_busy",  128'(bz4), 128'd1);
        wait4(lat);
        chk("c_lat",  128'(lat), 128'd10);
        chk("c_data", od4, CT_C);
        @(negedge clk);

        // Back-to-back with i_valid held
        blk = 0; outs = 0; cyc = 0; last = 0;
        v4 = 1'b1; d4 = bb_pt(0); k4 = bb_key(0);
        while (outs < 3 && cyc < 100) begin
            will_acc = rdy4 && v4;
            if (ov4) begin
                chk("bb_data", od4, bb_ct(outs));
                if (outs > 0) chk("bb_spacing", 128'(cyc - last), 128'd11);
                last = cyc;
                outs++;
            end
            @(negedge clk);
            cyc++;
            if (will_acc) begin
                blk++;
                if (blk < 3) begin
                    d4 = bb_pt(blk);
                    k4 = bb_key(blk);
                end else begin
                    v4 = 1'b0;
                end
            end
        end
        chk("bb_count", 128'(outs), 128'd3);
        v4 = 1'b0;
        @(negedge clk);

        // Key and data lines change while the block is in flight
        send4(PT_A, K_A);
        lat = 0;
        while (!ov4 && lat < 40) begin
            k4 = {$urandom(), $urandom(), $urandom(), $urandom()};
            d4 = {$urandom(), $urandom(), $urandom(), $urandom()};
            @(negedge clk);
            lat++;
        end
        chk("kc_lat",  128'(lat), 128'd10);
        chk("kc_data", od4, CT_A);
        @(negedge clk);

        // Reset in the middle of a block
        send4(PT_B, K_B);
        repeat (4) @(negedge clk);
        chk("mid_busy",  128'(bz4), 128'd1);
        chk("mid_ready", 128'(rdy4), 128'd0);
        chk("mid_valid", 128'(ov4), 128'd0);
        rst_n = 1'b0;
        #1;
        chk("mr_valid", 128'(ov4), 128'd0);
        chk("mr_data",  od4, 128'd0);
        chk("mr_busy",  128'(bz4), 128'd0);
        chk("mr_ready", 128'(rdy4), 128'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send4(PT_A, K_A);
        wait4(lat);
        chk("post_rst_lat",  128'(lat), 128'd10);
        chk("post_rst_data", od4, CT_A);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
